// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the SRAM arbiter: default widths, FSM encodings, grant IDs.
package ram_arbiter_pkg;
  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_RD1  = 3'd1;
  localparam state_t ST_RD2  = 3'd2;
  localparam state_t ST_WR1  = 3'd3;
  localparam state_t ST_WR2  = 3'd4;
  localparam state_t ST_WR3  = 3'd5;
  localparam state_t ST_DONE = 3'd6;

  localparam logic GNT_IF  = 1'b0;
  localparam logic GNT_MEM = 1'b1;
endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle: instruction-fetch port, memory-stage port and busy flag.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              busy;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack, busy
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
    output if_rdata, if_ack, mem_rdata, mem_ack, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one async 16-bit SRAM between fetch (read-only) and mem-stage (read/write)
// ports; round-robin on ties, fixed 3-cycle reads and 4-cycle writes.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] RamAddr,
  inout  wire  [DATA_W-1:0] RamData,
  output logic              RamOE,
  output logic              RamWE,
  output logic              RamEN
);

  state_t            r_state;
  logic              r_gnt;
  logic              r_last;
  logic              r_drive;
  logic [DATA_W-1:0] r_wdata;

  logic w_any;
  logic w_pick_mem;
  logic w_wr;

  // On a tie the port that did not win last time gets the SRAM.
  assign w_any      = bus.if_req | bus.mem_req;
  assign w_pick_mem = bus.mem_req & (~bus.if_req | (r_last == GNT_IF));
  assign w_wr       = w_pick_mem & bus.mem_we;

  assign bus.busy = (r_state != ST_IDLE);
  assign RamData  = r_drive ? r_wdata : {DATA_W{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_gnt         <= GNT_IF;
      r_last        <= GNT_IF;
      r_drive       <= 1'b0;
      r_wdata       <= '0;
      RamAddr       <= '0;
      RamEN         <= 1'b1;
      RamOE         <= 1'b1;
      RamWE         <= 1'b1;
      bus.if_ack    <= 1'b0;
      bus.mem_ack   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.mem_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_pick_mem;
            r_last  <= w_pick_mem;
            RamAddr <= w_pick_mem ? bus.mem_addr : bus.if_addr;
            RamEN   <= 1'b0;
            if (w_wr) begin
              r_wdata <= bus.mem_wdata;
              r_drive <= 1'b1;
              r_state <= ST_WR1;
            end else begin
              RamOE   <= 1'b0;
              r_state <= ST_RD1;
            end
          end
        end
        ST_RD1: r_state <= ST_RD2;
        ST_RD2: begin
          if (r_gnt == GNT_MEM) begin
            bus.mem_rdata <= RamData;
            bus.mem_ack   <= 1'b1;
          end else begin
            bus.if_rdata <= RamData;
            bus.if_ack   <= 1'b1;
          end
          RamEN   <= 1'b1;
          RamOE   <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_WR1: begin
          RamWE   <= 1'b0;
          r_state <= ST_WR2;
        end
        ST_WR2: begin
          RamWE   <= 1'b1;
          r_state <= ST_WR3;
        end
        ST_WR3: begin
          RamEN       <= 1'b1;
          r_drive     <= 1'b0;
          bus.mem_ack <= 1'b1;
          r_state     <= ST_DONE;
        end
        // One dead cycle so a request still held during ack is not served twice.
        ST_DONE: begin
          bus.if_ack  <= 1'b0;
          bus.mem_ack <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
